// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the RV32I instruction-fetch
//               stage: FSM state encoding, the canonical NOP encoding and the
//               sequential PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // HALT is only reachable when FETCH_MISALIGN_CHK_EN is defined.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch plus IF/ID pipeline register.
//               One instruction-memory request outstanding at a time; the
//               returned word is loaded into IF/ID, or parked in a hold buffer
//               while decode stalls. Execute-stage redirects retarget the PC
//               and kill any in-flight response.
// Macro       : FETCH_MISALIGN_CHK_EN - when defined, a redirect to a
//               non-word-aligned target sets the sticky fetch_misalign flag
//               and halts fetching until reset. When undefined the low two
//               target bits are ignored and fetch_misalign is tied 0.
// Ports       : clk, rst_n (async, active low)
//               imem_req_valid/addr/ready     - fetch request handshake
//               imem_rsp_valid/data           - instruction response
//               stall_d, flush_d              - decode back-pressure/flush
//               redirect_valid, redirect_pc   - taken branch/jump target
//               instr_d, pc_d, pcplus4_d,
//               valid_d                       - IF/ID register to decode
//               fetch_misalign                - sticky misaligned redirect
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d,
    output logic            fetch_misalign
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pcp4_q, ifid_pcp4_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            misalign_q, misalign_d;

    logic            accept;
    logic            load;
    logic [31:0]     load_instr;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] redir_target;
    logic            redir_misaligned;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redir_target     = redirect_pc;
    assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_misalign   = misalign_q;
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^{redirect_pc[1:0], misalign_q};
    assign redir_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign redir_misaligned = 1'b0;
    assign fetch_misalign   = 1'b0;
`endif

    // Gated with rst_n so no request is presented while held in reset.
    assign imem_req_valid = rst_n && (state_q == REQ);
    assign imem_req_addr  = pc_f_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // ------------------------------------------------------------------------
    // Fetch FSM / PC / hold buffer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        misalign_d   = misalign_q;
        load         = 1'b0;
        load_instr   = imem_rsp_data;
        load_pc      = req_pc_q;

        case (state_q)
            REQ: begin
                if (accept) begin
                    req_pc_d = pc_f_q;
                    pc_f_d   = pc_f_q + STEP;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else if (!stall_d) begin
                        load = 1'b1;
                    end else begin
                        hold_instr_d = imem_rsp_data;
                        hold_pc_d    = req_pc_q;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_d) begin
                    load       = 1'b1;
                    load_instr = hold_instr_q;
                    load_pc    = hold_pc_q;
                    state_d    = REQ;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = REQ;
        endcase

        // Redirect overrides everything except a halted front end. A
        // response landing in the redirect cycle is simply dropped, so kill
        // is only armed when a request is still genuinely in flight.
        if (redirect_valid && (state_q != HALT)) begin
            pc_f_d = redir_target;
            load   = 1'b0;
            if (redir_misaligned) begin
                misalign_d = 1'b1;
                kill_d     = 1'b0;
                state_d    = HALT;
            end else if (((state_q == WAIT) && !imem_rsp_valid) ||
                         ((state_q == REQ) && accept)) begin
                kill_d  = 1'b1;
                state_d = WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = REQ;
            end
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID register. An instruction lives for one cycle unless decode
    // stalls; when not reloaded it turns into a NOP bubble.
    // ------------------------------------------------------------------------
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pcp4_d  = ifid_pcp4_q;
        ifid_valid_d = ifid_valid_q;

        if (flush_d || redirect_valid) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (load) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = load_instr;
            ifid_pc_d    = load_pc;
            ifid_pcp4_d  = load_pc + STEP;
        end else if (!stall_d) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_f_q       <= RESET_PC;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pcp4_q  <= '0;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pcp4_q  <= ifid_pcp4_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign instr_d   = ifid_instr_q;
    assign pc_d      = ifid_pc_q;
    assign pcplus4_d = ifid_pcp4_q;
    assign valid_d   = ifid_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A per-cycle vector table
//               covers start-up, ready back-pressure and decode stall; hand
//               sequences cover redirect/kill, flush, PC wrap and reset in
//               the middle of a transaction. A behavioural memory pushes
//               every accepted address to a scoreboard, popped whenever a
//               new instruction appears in IF/ID. Honours FETCH_MISALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_d;
    logic        flush_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        fetch_misalign;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pcplus4_d      (pcplus4_d),
        .valid_d        (valid_d),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ready;
        logic        stall;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_vd;
        logic [31:0] exp_pcd;
    } vec_t;
    vec_t vecs [12];

    // memory model / scoreboard state
    logic [31:0] sb [$];
    int          rsp_lat;
    bit          m_acc, m_rsp_now, m_pend;
    logic [31:0] m_acc_addr, m_pend_addr;
    int          m_cnt;
    // IF/ID monitor history
    bit          pv, ps, pf;
    logic [31:0] ppc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h0ABC_0013);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        bit held, is_new;
        logic [31:0] a;
        if (!rst_n) begin
            pv = 0; ps = 0; pf = 0;
            return;
        end
        held   = pv && ps && !pf;
        is_new = valid_d && !held;
        if (held) begin
            chk("hold_valid", valid_d, 1);
            chk("hold_pc", pc_d, ppc);
        end
        if (is_new) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_instr: got pc %h expected none", pc_d);
            end else begin
                a = sb.pop_front();
                chk("sb_pc", pc_d, a);
                chk("sb_pcplus4", pcplus4_d, a + 32'd4);
                chk("sb_instr", instr_d, mem_word(a));
            end
        end
        if (!valid_d) chk("bubble_nop", instr_d, NOP);
        pv  = valid_d;
        ps  = stall_d;
        pf  = flush_d || redirect_valid;
        ppc = pc_d;
    endtask

    task automatic neg();
        @(negedge clk);
        m_acc      = rst_n && imem_req_valid && imem_req_ready;
        m_acc_addr = imem_req_addr;
        m_rsp_now  = imem_rsp_valid;
        monitor();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            imem_rsp_valid = 0; m_pend = 0; m_cnt = 0;
        end else begin
            if (m_rsp_now) imem_rsp_valid = 0;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    imem_rsp_valid = 1; imem_rsp_data = mem_word(m_pend_addr); m_pend = 0;
                end
            end
            if (m_acc) begin
                sb.push_back(m_acc_addr);
                if (rsp_lat == 0) begin
                    imem_rsp_valid = 1; imem_rsp_data = mem_word(m_acc_addr);
                end else begin
                    m_pend = 1; m_cnt = rsp_lat; m_pend_addr = m_acc_addr;
                end
            end
        end
        #1;
    endtask

    task automatic wait_req(input string name, input int maxc);
        int n = 0;
        bit found = 0;
        while (!found && n < maxc) begin
            if (n > 0) pos();
            neg();
            found = imem_req_valid;
            n++;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no request expected request", name);
        end
    endtask

    task automatic wait_vd(input string name, input int maxc);
        int n = 0;
        bit found = 0;
        while (!found && n < maxc) begin
            if (n > 0) pos();
            neg();
            found = valid_d;
            n++;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got valid_d 0 expected 1", name);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit found;
        rst_n = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        stall_d = 0; flush_d = 0; redirect_valid = 0; redirect_pc = 0;
        rsp_lat = 0; m_pend = 0; m_cnt = 0; m_acc = 0; m_rsp_now = 0;
        pv = 0; ps = 0; pf = 0; ppc = 0;

        //             ready stall rv  addr          vd  pc_d
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8};

        // reset state
        pos(); neg();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_valid_d", valid_d, 0);
        chk("rst_instr_d", instr_d, NOP);
        chk("rst_pc_d", pc_d, 0);
        chk("rst_pcplus4_d", pcplus4_d, 0);
        chk("rst_misalign", fetch_misalign, 0);
        pos(); neg(); pos();
        rst_n = 1;

        // start-up, ready back-pressure, decode stall into HOLD
        for (int i = 0; i < 12; i++) begin
            imem_req_ready = vecs[i].ready;
            stall_d        = vecs[i].stall;
            neg();
            chk($sformatf("v%0d_req_valid", i), imem_req_valid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid_d", i), valid_d, vecs[i].exp_vd);
            if (vecs[i].exp_vd) begin
                chk($sformatf("v%0d_pc_d", i), pc_d, vecs[i].exp_pcd);
                chk($sformatf("v%0d_pcplus4_d", i), pcplus4_d, vecs[i].exp_pcd + 32'd4);
            end
            pos();
        end

        // redirect while waiting on 0xC: its late response must be killed
        imem_req_ready = 1; stall_d = 0; rsp_lat = 2;
        neg(); pos();
        redirect_valid = 1; redirect_pc = 32'h100;
        neg();
        chk("redir_in_wait", imem_req_valid, 0);
        pos();
        redirect_valid = 0; sb.delete(); rsp_lat = 0;
        neg();
        chk("redir_valid_d", valid_d, 0);
        chk("redir_instr_nop", instr_d, NOP);
        pos();
        wait_req("redir_req", 10);
        chk("redir_req_addr", imem_req_addr, 32'h100);
        pos();
        wait_vd("redir_vd", 10);
        chk("redir_first_pc", pc_d, 32'h100);

        // flush together with stall
        pos();
        n = 0; found = 0;
        while (!found && n < 10) begin
            if (n > 0) pos();
            neg();
            found = !valid_d && !imem_req_valid && imem_rsp_valid;
            n++;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL flush_setup_timeout: got no response expected response");
        end
        pos();
        stall_d = 1; flush_d = 1;
        neg();
        chk("flush_pre_valid", valid_d, 1);
        pos();
        stall_d = 0; flush_d = 0;
        neg();
        chk("flush_valid_d", valid_d, 0);
        chk("flush_instr_nop", instr_d, NOP);

`ifndef FETCH_MISALIGN_CHK_EN
        // misaligned target: low bits ignored
        pos();
        redirect_valid = 1; redirect_pc = 32'h102;
        neg(); pos();
        redirect_valid = 0; sb.delete();
        wait_req("misal_req", 10);
        chk("misal_req_addr", imem_req_addr, 32'h100);
        chk("misal_flag", fetch_misalign, 0);
`endif

        // PC wrap at the top of the address space
        pos();
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        neg(); pos();
        redirect_valid = 0; sb.delete();
        wait_req("wrap_req0", 10);
        chk("wrap_req0_addr", imem_req_addr, 32'hFFFF_FFFC);
        pos();
        wait_req("wrap_req1", 10);
        chk("wrap_req1_addr", imem_req_addr, 32'h0);
        chk("wrap_valid_d", valid_d, 1);
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pcplus4_d", pcplus4_d, 32'h0);

        // reset while a slow response is outstanding
        pos();
        rsp_lat = 3;
        wait_req("mid_req", 10);
        pos();
        neg();
        chk("mid_in_wait", imem_req_valid, 0);
        pos();
        rst_n = 0; sb.delete();
        #1;
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_valid_d", valid_d, 0);
        chk("mid_rst_instr", instr_d, NOP);
        chk("mid_rst_pc_d", pc_d, 0);
        neg(); pos();
        rsp_lat = 0;
        neg(); pos();
        rst_n = 1;
        wait_req("post_rst_req", 2);
        chk("post_rst_addr", imem_req_addr, 32'h0);
        pos();
        wait_vd("post_rst_vd", 10);
        chk("post_rst_pc_d", pc_d, 32'h0);
        chk("post_rst_instr", instr_d, 32'h0050_0093);

`ifdef FETCH_MISALIGN_CHK_EN
        // misaligned target halts fetch until reset
        pos();
        redirect_valid = 1; redirect_pc = 32'h102;
        neg(); pos();
        redirect_valid = 0; sb.delete();
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("halt_req_valid", imem_req_valid, 0);
            chk("halt_misalign", fetch_misalign, 1);
            chk("halt_valid_d", valid_d, 0);
            pos();
        end
        rst_n = 0;
        neg();
        chk("halt_rst_misalign", fetch_misalign, 0);
        pos();
        rst_n = 1;
        neg();
        chk("halt_exit_req", imem_req_valid, 1);
        chk("halt_exit_addr", imem_req_addr, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- RV32I instruction-fetch stage plus IF/ID pipeline register for the pipelined core.
- Holds the PC and issues one instruction-memory request at a time with a valid/ready handshake.
- Captures the returned word and presents instr_d/pc_d/pcplus4_d to decode, where the immediate extender consumes instr_d[31:7].
- Supports decode stall, decode flush and execute-stage redirect (taken branch/jump target = PC + immext, computed downstream).

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address; word-aligned.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response word valid; arrives no earlier than the cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- stall_d  in  1  decode cannot accept; IF/ID register holds.
- flush_d  in  1  invalidate IF/ID contents.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  XLEN  redirect target.
- instr_d  out  32  instruction to decode.
- pc_d  out  XLEN  PC of instr_d.
- pcplus4_d  out  XLEN  pc_d + 4.
- valid_d  out  1  instr_d holds a live instruction.
- fetch_misalign  out  1  sticky misaligned-redirect flag; tied 0 without the macro.

Behaviour:
- Reset (async, rst_n=0):
  - pc_f=RESET_PC; state=REQ; kill=0.
  - valid_d=0, instr_d=NOP (32'h0000_0013), pc_d=0, pcplus4_d=0.
  - imem_req_valid=0 while in reset; asserts in the first cycle after rst_n rises.
  - Reset mid-transaction discards any outstanding response; memory is reset alongside.
- Single outstanding request. Best-case throughput is 1 instruction per 2 cycles.
- FSM states are REQ, WAIT, HOLD (plus HALT with the macro).
- REQ:
  - imem_req_valid=1, imem_req_addr=pc_f.
  - On accept (valid & ready): req_pc<=pc_f, pc_f<=pc_f+4, go to WAIT.
  - Address is held stable while ready=0.
- WAIT:
  - imem_req_valid=0.
  - On rsp_valid with kill=1: discard the word, kill<=0, go to REQ.
  - On rsp_valid with kill=0 and stall_d=0: load the IF/ID register (instr_d=rsp_data, pc_d=req_pc, pcplus4_d=req_pc+4, valid_d=1), go to REQ.
  - On rsp_valid with kill=0 and stall_d=1: capture word and req_pc into the hold buffer, go to HOLD.
- HOLD:
  - No request is issued.
  - When stall_d=0: load the IF/ID register from the hold buffer, go to REQ.
- Redirect (highest priority):
  - pc_f<=redirect_pc and valid_d<=0.
  - Hold buffer is dropped.
  - If a request is outstanding (WAIT, or accepted this same cycle in REQ): kill<=1, state WAIT.
  - Otherwise state is REQ.
  - A response arriving in the same cycle as redirect is discarded and kill is not set.
- IF/ID register:
  - flush_d or redirect_valid clears valid_d, with priority over load and stall.
  - stall_d=1 without flush holds all *_d outputs.
  - instr_d is forced to NOP when valid_d is cleared.
- PC arithmetic is modulo 2^XLEN; pc_f=32'hFFFF_FFFC wraps to 0.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - redirect_valid with redirect_pc[1:0]!=0 sets fetch_misalign (sticky until reset) and clears valid_d.
  - FSM enters HALT: no further requests, any pending response is ignored.
  - HALT exits only on reset.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00.
  - fetch_misalign is tied 0; no HALT state.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e enum (REQ, WAIT, HOLD, HALT).
  - NOP_INSTR constant 32'h0000_0013.
  - PC_STEP constant 4.
- No sub-module: the hold buffer and IF/ID register are inline.

Test Plan:
- Reset release, ready=1, rsp one cycle after accept with 32'h00500093: requests to 0x0, 0x4, 0x8 on alternate cycles. Two cycles after the first accept, instr_d=32'h00500093, pc_d=0x0, pcplus4_d=0x4, valid_d=1.
- imem_req_ready low for 3 cycles: imem_req_addr held at 0x4 and valid held high. pc_f advances only on accept.
- stall_d=1 when the response for 0x8 arrives: IF/ID register holds 0x4's instruction, state HOLD, no request. After stall drops, the next cycle shows pc_d=0x8, and the request to 0xC follows.
- redirect_valid with redirect_pc=0x100 while WAIT on 0xC: 0xC's response is discarded and valid_d=0. The next request is 0x100, and the first live instr_d has pc_d=0x100.
- flush_d and stall_d asserted together: valid_d=0, instr_d=NOP next cycle.
- With FETCH_MISALIGN_CHK_EN, redirect_pc=0x102: fetch_misalign=1, valid_d=0, imem_req_valid stays 0 until rst_n pulse. Without the macro, the next request address is 0x100.
